// File: rtl/cond_issue_ctrl.sv
// rtl/cond_issue_ctrl.sv - NZCV holder, ARM condition evaluation and flag-hazard issue stall.
// Optional feature macro: COND_FLAG_BYPASS_EN (forward flag_in to the instruction issued with flag_we).
module cond_issue_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_cond,
  input  logic       in_set_flags,
  input  logic       in_multi,
  input  logic       flag_we,
  input  logic [3:0] flag_in,
  output logic       ex_valid,
  output logic       ex_exec,
  output logic [3:0] nzcv,
  output logic       flags_busy,
  output logic       err
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [3:0] LAT_MULTI = 4'(MUL_LAT);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] nzcv_n;
  logic       err_n;
  logic [3:0] f_eff;
  logic       pass;
  logic       issue;
  logic       setter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      nzcv     <= 4'd0;
      err      <= 1'b0;
      ex_valid <= 1'b0;
      ex_exec  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      nzcv     <= nzcv_n;
      err      <= err_n;
      ex_valid <= issue;
      ex_exec  <= issue & pass;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (state == IDLE) begin
        in_ready = 1'b1;
      end else begin
`ifdef COND_FLAG_BYPASS_EN
        in_ready = flag_we;
`else
        in_ready = 1'b0;
`endif
      end
    end
  end

  // Flags seen by the instruction being issued this cycle.
  always_comb begin
    f_eff = nzcv;
`ifdef COND_FLAG_BYPASS_EN
    if (state == PEND && flag_we) f_eff = flag_in;
`endif
  end

  always_comb begin
    pass = 1'b0;
    case (in_cond)
      4'd0:  pass = f_eff[2];
      4'd1:  pass = !f_eff[2];
      4'd2:  pass = f_eff[1];
      4'd3:  pass = !f_eff[1];
      4'd4:  pass = f_eff[3];
      4'd5:  pass = !f_eff[3];
      4'd6:  pass = f_eff[0];
      4'd7:  pass = !f_eff[0];
      4'd8:  pass = f_eff[1] && !f_eff[2];
      4'd9:  pass = !f_eff[1] || f_eff[2];
      4'd10: pass = (f_eff[3] == f_eff[0]);
      4'd11: pass = (f_eff[3] != f_eff[0]);
      4'd12: pass = !f_eff[2] && (f_eff[3] == f_eff[0]);
      4'd13: pass = f_eff[2] || (f_eff[3] != f_eff[0]);
      default: pass = 1'b1;
    endcase
  end

  assign issue  = in_valid & in_ready;
  assign setter = issue & in_set_flags & pass;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    nzcv_n  = nzcv;
    err_n   = err;
    case (state)
      IDLE: begin
        if (flag_we) begin
          nzcv_n = flag_in;
          err_n  = 1'b1;
        end
        if (setter) begin
          state_n = PEND;
          cnt_n   = in_multi ? LAT_MULTI : 4'd1;
        end
      end
      PEND: begin
        if (flag_we) begin
          nzcv_n = flag_in;
          if (setter) begin
            state_n = PEND;
            cnt_n   = in_multi ? LAT_MULTI : 4'd1;
          end else begin
            state_n = IDLE;
            cnt_n   = 4'd0;
          end
        end else if (cnt == 4'd1) begin
          // Write-back never arrived: give up waiting and flag the protocol breach.
          state_n = IDLE;
          cnt_n   = 4'd0;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  assign flags_busy = (state == PEND);

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// tb/tb_cond_issue_ctrl.sv - directed self-checking bench for cond_issue_ctrl (MUL_LAT=3).
module tb_cond_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_cond;
  logic       in_set_flags;
  logic       in_multi;
  logic       flag_we;
  logic [3:0] flag_in;
  logic       ex_valid;
  logic       ex_exec;
  logic [3:0] nzcv;
  logic       flags_busy;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  cond_issue_ctrl #(.MUL_LAT(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_cond      (in_cond),
    .in_set_flags (in_set_flags),
    .in_multi     (in_multi),
    .flag_we      (flag_we),
    .flag_in      (flag_in),
    .ex_valid     (ex_valid),
    .ex_exec      (ex_exec),
    .nzcv         (nzcv),
    .flags_busy   (flags_busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Conditions come in true/inverted pairs; 14 and 15 are always.
  function automatic logic cref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy & ~z;
      3'd5: b = (n == v);
      3'd6: b = ~z & (n == v);
      default: return 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_cond = 4'd0; in_set_flags = 1'b0;
    in_multi = 1'b0; flag_we = 1'b0; flag_in = 4'd0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    tick(); tick();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_exec", ex_exec, 0);
    chk("rst_nzcv", nzcv, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", flags_busy, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // EQ on zero flags
    in_valid = 1'b1; in_cond = 4'd0;
    tick();
    in_valid = 1'b0;
    chk("eq_ex_valid", ex_valid, 1);
    chk("eq_ex_exec", ex_exec, 0);
    chk("eq_nzcv", nzcv, 0);
    chk("eq_err", err, 0);
    tick();
    chk("noissue_ex_valid", ex_valid, 0);

    // single-cycle AL setter, then dependent EQ
    in_valid = 1'b1; in_cond = 4'd14; in_set_flags = 1'b1; in_multi = 1'b0;
    tick();
    chk("s1_al_exec", ex_exec, 1);
    chk("s1_busy", flags_busy, 1);
    flag_we = 1'b1; flag_in = 4'b0100;
    in_valid = 1'b1; in_cond = 4'd0; in_set_flags = 1'b0;
    #1;
`ifdef COND_FLAG_BYPASS_EN
    chk("s1_bypass_ready", in_ready, 1);
    tick();
    flag_we = 1'b0; in_valid = 1'b0;
    chk("s1_eq_valid", ex_valid, 1);
    chk("s1_eq_exec", ex_exec, 1);
    chk("s1_nzcv", nzcv, 4'b0100);
`else
    chk("s1_stall_ready", in_ready, 0);
    tick();
    flag_we = 1'b0;
    chk("s1_stall_ex_valid", ex_valid, 0);
    chk("s1_nzcv", nzcv, 4'b0100);
    chk("s1_ready_after", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("s1_eq_valid", ex_valid, 1);
    chk("s1_eq_exec", ex_exec, 1);
`endif
    chk("s1_err", err, 0);

    // multi-cycle setter, flags return at T+3
    in_valid = 1'b1; in_cond = 4'd14; in_set_flags = 1'b1; in_multi = 1'b1;
    tick();
    in_valid = 1'b0; in_set_flags = 1'b0; in_multi = 1'b0;
    chk("m_busy_t1", flags_busy, 1);
    chk("m_ready_t1", in_ready, 0);
    tick();
    chk("m_busy_t2", flags_busy, 1);
    chk("m_ready_t2", in_ready, 0);
    tick();
    chk("m_busy_t3", flags_busy, 1);
    flag_we = 1'b1; flag_in = 4'b1000;
    tick();
    flag_we = 1'b0;
    chk("m_nzcv", nzcv, 4'b1000);
    chk("m_busy_t4", flags_busy, 0);
    chk("m_err", err, 0);
    in_valid = 1'b1; in_cond = 4'd4;
    tick();
    in_valid = 1'b0;
    chk("m_mi_exec", ex_exec, 1);

    // load 0100, then failing NE setter must not enter PEND
    in_valid = 1'b1; in_cond = 4'd14; in_set_flags = 1'b1;
    tick();
    in_valid = 1'b0;
    flag_we = 1'b1; flag_in = 4'b0100;
    tick();
    flag_we = 1'b0;
    chk("ne_nzcv", nzcv, 4'b0100);
    in_valid = 1'b1; in_cond = 4'd1; in_set_flags = 1'b1;
    tick();
    in_valid = 1'b0; in_set_flags = 1'b0;
    chk("ne_valid", ex_valid, 1);
    chk("ne_exec", ex_exec, 0);
    chk("ne_busy", flags_busy, 0);
    chk("ne_ready", in_ready, 1);
    chk("ne_err", err, 0);

    // multi setter whose flags never come back
    in_valid = 1'b1; in_cond = 4'd14; in_set_flags = 1'b1; in_multi = 1'b1;
    tick();
    in_valid = 1'b0; in_set_flags = 1'b0; in_multi = 1'b0;
    tick(); tick();
    chk("to_busy_t3", flags_busy, 1);
    chk("to_err_t3", err, 0);
    tick();
    chk("to_busy_idle", flags_busy, 0);
    chk("to_err", err, 1);
    chk("to_nzcv", nzcv, 4'b0100);

    // reset while pending, then spurious flag_we
    rst_n = 1'b0;
    #1;
    chk("r2_err_clr", err, 0);
    rst_n = 1'b1;
    in_valid = 1'b1; in_cond = 4'd14; in_set_flags = 1'b1; in_multi = 1'b1;
    tick();
    in_valid = 1'b0; in_set_flags = 1'b0; in_multi = 1'b0;
    chk("r2_busy", flags_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("r2_busy_async", flags_busy, 0);
    chk("r2_ready_rst", in_ready, 0);
    tick();
    rst_n = 1'b1;
    flag_we = 1'b1; flag_in = 4'b0011;
    tick();
    flag_we = 1'b0;
    chk("sp_err", err, 1);
    chk("sp_nzcv", nzcv, 4'b0011);
    chk("sp_busy", flags_busy, 0);

    // condition sweep over all flag values
    for (int v = 0; v < 16; v++) begin
      flag_we = 1'b1; flag_in = 4'(v);
      tick();
      flag_we = 1'b0;
      for (int c = 0; c < 16; c++) begin
        in_valid = 1'b1; in_cond = 4'(c);
        tick();
        chk($sformatf("sweep_c%0d_f%0h", c, v), ex_exec, cref(4'(c), 4'(v)));
      end
      in_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
